mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit placed directly downstream of the register bank. It consumes the registered read ports RD1/RD2 as operands and returns its result to the bank's write port (WD3/A3/WE3), with the active-low write strobe generated internally. One operation runs at a time; a single-bit start launches it and a one-cycle done pulse ends it. It covers the calculator's MUL, UDIV and UREM operations, which the single-cycle ALU does not implement.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled on posedge only while in IDLE.
- op  in  2  00 MUL (low 32 bits of product), 01 UDIV (quotient), 10 UREM (remainder), 11 illegal.
- dest  in  4  destination register index; latched at start.
- RD1  in  32  operand A (multiplicand/dividend), from the register bank read port 1.
- RD2  in  32  operand B (multiplier/divisor), from the register bank read port 2.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  sticky until next accepted start: divide by zero or illegal op.
- WD3  out  32  result, held from DONE until the next DONE.
- A3  out  4  latched dest.
- WE3  out  1  active-low write strobe to the bank; low only during a writing DONE cycle.

## Operation
- States: IDLE, RUN, DONE. Counter cnt is 5 bits.
- IDLE with start=1 and op≠11: latch op, dest, RD1 and RD2; clear acc/rem, cnt=0 and err; go to RUN.
- IDLE with start=1 and op=11: set err=1 and go to DONE with no write (WE3 stays 1). WD3 keeps its previous value.
- RUN, MUL: shift-add, LSB-first. Each cycle, if multiplier[0] then acc += multiplicand. Multiplicand shifts left and multiplier shifts right. Arithmetic is modulo 2^32; higher bits are discarded.
- RUN, UDIV/UREM: restoring division, MSB-first. rem = {rem[30:0], dividend[31]}. If rem ≥ divisor, subtract and shift in a 1 to the quotient, else shift in a 0. Use a 33-bit compare so no overflow occurs.
- RUN: cnt increments each cycle. When cnt=31, the result is final and the next state is DONE.
- Divide by zero (divisor=0 at start): still run 32 cycles. Quotient results in 0xFFFFFFFF and remainder in the dividend, which the restoring algorithm yields naturally. err=1, and the write still occurs.
- DONE: drive WD3 with the result, done=1, and WE3=0 (unless illegal op). Return to IDLE next cycle.
- start while busy is ignored and not queued.
- dest=15 is written like any other register; the unit has no special case for it.
- Reset (any time, including mid-RUN): state=IDLE. busy=0, done=0, err=0, WD3=0, A3=0, WE3=1. The partial result is discarded.

## Timing
- Operands must be valid on RD1/RD2 at the posedge where start is sampled. The bank's read is registered, so the controller drives A1/A2 one cycle before asserting start.
- Start accepted at posedge N: busy=1 after N. RUN spans N+1..N+32, and DONE is the cycle after posedge N+32. Latency is 33 cycles start-to-done; throughput is one operation per 34 cycles.
- Illegal op: done one cycle after the start edge (2-cycle occupancy).
- WE3 is low for exactly the DONE cycle. The bank writes on the negedge inside that cycle, so the new value is readable via RD1/RD2 at the next posedge read.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- MUL: RD1=7, RD2=6, start, dest=3 -> done 33 cycles later. WD3=42, A3=3, WE3=0 for one cycle, err=0.
- MUL wrap: 0xFFFFFFFF × 0xFFFFFFFF -> WD3=0x00000001. Also 0x80000000 × 2 -> WD3=0.
- UDIV/UREM: 100/7 -> WD3=14; 100%7 -> WD3=2. Also 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide by zero: UDIV 5/0 -> WD3=0xFFFFFFFF, err=1, WE3=0. UREM 5/0 -> WD3=5, err=1.
- Illegal op=11 -> done on the 2nd cycle, err=1, WE3 stays 1, WD3 unchanged. start pulsed during RUN -> ignored, first result unaffected, busy contiguous.
- Reset mid-RUN at cycle 15 -> outputs go to reset values immediately (async). No WE3 pulse ever occurs. A new MUL 3×4 after release -> WD3=12.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MUL/UDIV/UREM unit that writes its result back to the register bank
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [3:0]       dest,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] WD3,
    output logic [3:0]       A3,
    output logic             WE3
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [1:0]       r_op;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_rem;
    logic [WIDTH:0]   w_rem_sh, w_sub;
    logic [WIDTH-1:0] w_prod, w_quo, w_rem_n, w_res;
    logic             w_ge, w_accept, w_last;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_accept = r_state == IDLE && start;
        w_last   = r_state == RUN && r_cnt == 5'd31;
        w_next   = w_accept ? (op == 2'b11 ? DONE : RUN) : w_last ? DONE : r_state == RUN ? RUN : IDLE;
    end
    // bit WIDTH of the 33-bit difference is the borrow, so no-borrow means rem >= divisor
    always_comb begin
        w_prod   = r_acc + (r_b[0] ? r_a : '0);
        w_rem_sh = {r_rem, r_a[WIDTH-1]};
        w_sub    = w_rem_sh - {1'b0, r_b};
        w_ge     = ~w_sub[WIDTH];
        w_rem_n  = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo    = {r_acc[WIDTH-2:0], w_ge};
        w_res    = r_op == 2'b00 ? w_prod : r_op == 2'b01 ? w_quo : w_rem_n;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            WD3   <= '0;
            A3    <= '0;
            WE3   <= 1'b1;
            r_op  <= '0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
        end else begin
            busy <= w_next != IDLE;
            done <= w_next == DONE;
            WE3  <= !w_last;
            if (w_accept) begin
                err <= op == 2'b11 || (op != 2'b00 && RD2 == '0);
                if (op != 2'b11) begin
                    r_op  <= op;
                    A3    <= dest;
                    r_a   <= RD1;
                    r_b   <= RD2;
                    r_acc <= '0;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 5'd1;
                r_acc <= r_op == 2'b00 ? w_prod : w_quo;
                r_a   <= r_a << 1;
                r_b   <= r_op == 2'b00 ? r_b >> 1 : r_b;
                r_rem <= w_rem_n;
                if (w_last) WD3 <= w_res;
            end
        end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a queue scoreboard checked on every done pulse
module tb_mul_div_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]  op = '0;
    logic [3:0]  dest = '0;
    logic [31:0] RD1 = '0, RD2 = '0;
    logic        busy, done, err, WE3;
    logic [31:0] WD3;
    logic [3:0]  A3;

    typedef struct {
        logic [31:0] wd3;
        logic [3:0]  a3;
        logic        err;
        logic        we3;
        logic        chk_a3;
        int          dcyc;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   cyc = 0, checks = 0, passed = 0, busy_gaps = 0, stray_we = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dest(dest),
        .RD1(RD1), .RD2(RD2), .busy(busy), .done(done), .err(err),
        .WD3(WD3), .A3(A3), .WE3(WE3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() != 0 && !busy) busy_gaps++;
        if (rst_n && !WE3 && !done) stray_we++;
        if (rst_n && done) begin
            chk("queue_depth_at_done", sb.size(), 1);
            if (sb.size() != 0) begin
                m = sb.pop_front();
                chk("WD3", WD3, m.wd3);
                if (m.chk_a3) chk("A3", {28'd0, A3}, {28'd0, m.a3});
                chk("err", {31'd0, err}, {31'd0, m.err});
                chk("WE3", {31'd0, WE3}, {31'd0, m.we3});
                chk("done_cycle", cyc, m.dcyc);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input logic [31:0] wd, input logic e_err,
                         input logic e_we3, input logic chk_a3, input logic push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; RD1 = a; RD2 = b; dest = d;
        e.wd3 = wd; e.a3 = d; e.err = e_err; e.we3 = e_we3; e.chk_a3 = chk_a3;
        e.dcyc = cyc + 1 + (o == 2'b11 ? 0 : 32);
        @(posedge clk);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_err"}, {31'd0, err}, 0);
        chk({tag, "_WD3"}, WD3, 0);
        chk({tag, "_A3"}, {28'd0, A3}, 0);
        chk({tag, "_WE3"}, {31'd0, WE3}, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 4'd3, 32'd42, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b00, 32'h8000_0000, 32'd2, 4'd15, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b01, 32'd100, 32'd7, 4'd1, 32'd14, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b10, 32'd100, 32'd7, 4'd2, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b11, 32'd9, 32'd9, 4'd8, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1); wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b01, 32'd5, 32'd0, 4'd6, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1); wait_done();
        issue(2'b10, 32'd5, 32'd0, 4'd7, 32'd5, 1'b1, 1'b0, 1'b1, 1'b1); wait_done();
        // a second start mid-run must be dropped without disturbing the first operation
        issue(2'b00, 32'd7, 32'd6, 4'd3, 32'd42, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; op = 2'b01; RD1 = 32'd100; RD2 = 32'd0; dest = 4'd11;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(2'b00, 32'd1234, 32'd5678, 4'd10, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd3, 32'd4, 4'd9, 32'd12, 1'b0, 1'b0, 1'b1, 1'b1); wait_done();
        chk("busy_gaps", busy_gaps, 0);
        chk("we3_outside_done", stray_we, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
